cga_hdmi_de_gen: RTL and testbench
==================================

// Module: cga_hdmi_de_gen
// PURPOSE
//  Regenerates a clean, frame-locked display-enable for the HDMI output port from raw CGA video and syncs.
//  Sits directly upstream of the HDMI port stage.
//  - Counts dot clocks from the hsync leading edge and lines from the vsync leading edge.
//  - Asserts DE only inside a programmable active window.
//  - Blanks video outside that window.
//  - Delays video and syncs so all outputs stay mutually aligned.
// PARAMETERS
//  HW        10   horizontal counter width (bits)
//  VW        9    vertical counter width (bits)
//  H_START   120  first active dot, counted from the hsync leading edge (0 = edge dot)
//  H_ACTIVE  640  active dots per line
//  V_START   36   first active line, counted from the vsync leading edge
//  V_ACTIVE  200  active lines per frame
//  SYNC_POL  1    1 = syncs active-high, 0 = active-low (inputs and outputs share the polarity)
//  REQ_LOCK  1    1 = de_out is forced low while locked = 0
// PORTS
//  clk        in   1   dot clock; every rising edge is one pixel
//  reset_n    in   1   asynchronous, active-low reset
//  video      in   4   raw IRGB pixel {I,R,G,B}
//  hsync      in   1   raw horizontal sync
//  vsync      in   1   raw vertical sync
//  video_out  out  4   IRGB, forced to 4'h0 when de_out = 0
//  de_out     out  1   display enable to the HDMI port
//  hsync_out  out  1   hsync, delayed to align with video_out
//  vsync_out  out  1   vsync, delayed to align with video_out
//  locked     out  1   frame line count is stable
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - video_out = 0, de_out = 0, locked = 0.
//   - hsync_out / vsync_out = inactive level (~SYNC_POL).
//   - All counters and frame_lines = 0.
//  Pipeline: fixed 2-clk latency for every output.
//   - S1 registers the inputs and the previous sync levels.
//   - S2 registers the outputs.
//  Edges: h_edge = S1 hsync active && previous S1 hsync inactive. v_edge is the same for vsync.
//  h_cnt for the S1 dot:
//   - 0 on h_edge; otherwise previous value + 1.
//   - Saturates at 2^HW-1 (no wrap) when hsync is missing.
//  v_cnt:
//   - Increments (saturating at 2^VW-1) on h_edge.
//   - Cleared to 0 on v_edge.
//   - If h_edge and v_edge fall on the same clk, v_edge wins: v_cnt = 0.
//  Window:
//   - win = (H_START <= h_cnt < H_START+H_ACTIVE) && (V_START <= v_cnt < V_START+V_ACTIVE).
//   - Bounds are compared at full counter width; no truncation.
//  Lock logic, evaluated on each v_edge:
//   - frame_lines <= v_cnt (value before clear).
//   - locked <= 1 iff v_cnt == frame_lines && v_cnt != 0; otherwise locked <= 0.
//   - Two consecutive equal frames are therefore needed to lock, and one mismatch drops lock.
//   - v_cnt saturation forces the next comparison to fail unless the previous frame also saturated.
//  Outputs (S2):
//   - de_out = win && (locked || !REQ_LOCK).
//   - video_out = de_out ? S1 video : 0.
//   - Syncs are passed through unmodified.
//  Reset mid-frame: everything returns to reset values; lock is regained after 2 full frames.
//  No combinational path from any input to any output.
// TESTING
//  1 Reset: hold reset_n=0 with video=4'hF and syncs toggling
//    -> all outputs at reset values; locked=0.
//  2 Latency: REQ_LOCK=0, single hsync pulse, then video=4'hA on the dot where h_cnt=120 in line v_cnt=36
//    -> video_out=4'hA and de_out=1 exactly 2 clks later; the dot at h_cnt=119 gives de_out=0, video_out=0.
//  3 Window edges: line-end dot h_cnt=759 -> de_out=1; dot 760 -> 0; line v_cnt=235 -> DE active; line 236 -> de_out=0.
//  4 Lock: 3 frames of 262 lines (912 dots/line)
//    -> locked rises on the 2nd frame's v_edge (+1 clk); de_out active on frame 3 only.
//    A following 263-line frame -> locked=0 at its v_edge.
//  5 Simultaneous edges: h_edge and v_edge on the same clk -> v_cnt=0, h_cnt=0.
//    Missing hsync for 1100 dots -> h_cnt holds at 1023 with de_out=0.
//  6 Polarity: SYNC_POL=0 with low-going syncs
//    -> same DE timing as case 2; hsync_out/vsync_out idle high after reset.

Source files
------------

// File: rtl/cga_hdmi_de_gen.sv
// cga_hdmi_de_gen: regenerates a frame-locked display enable for the HDMI port from raw CGA
// video and syncs. Dots are counted from the hsync leading edge and lines from the vsync leading
// edge. DE is asserted only inside the programmed active window, and video is blanked outside it.
// Every output has a fixed two-clock latency, so video, DE and syncs stay mutually aligned.
//
// Ports:
//   clk        dot clock, one pixel per rising edge
//   reset_n    asynchronous active-low reset
//   video      raw IRGB pixel {I,R,G,B}
//   hsync      raw horizontal sync (polarity set by SYNC_POL)
//   vsync      raw vertical sync (polarity set by SYNC_POL)
//   video_out  IRGB, forced to 0 whenever de_out is low
//   de_out     display enable
//   hsync_out  hsync delayed to align with video_out
//   vsync_out  vsync delayed to align with video_out
//   locked     two consecutive frames had the same non-zero line count
module cga_hdmi_de_gen #(
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 9,
  parameter int unsigned H_START  = 120,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_START  = 36,
  parameter int unsigned V_ACTIVE = 200,
  parameter bit          SYNC_POL = 1'b1,
  parameter bit          REQ_LOCK = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] video,
  input  logic       hsync,
  input  logic       vsync,
  output logic [3:0] video_out,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       locked
);

  localparam int unsigned    HEnd    = H_START + H_ACTIVE;
  localparam int unsigned    VEnd    = V_START + V_ACTIVE;
  localparam logic [HW-1:0]  HMax    = '1;
  localparam logic [VW-1:0]  VMax    = '1;
  localparam logic           SyncOff = ~SYNC_POL;

  // Stage 1: registered inputs plus the previous registered sync levels.
  logic [3:0]    s1_video_q;
  logic          s1_hs_q, s1_vs_q;
  logic          s1_hs_prev_q, s1_vs_prev_q;

  // Counters hold the position of the dot currently in stage 1 once it has been counted.
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [VW-1:0] frame_lines_q, frame_lines_d;
  logic          locked_q, locked_d;

  // Stage 2: output registers.
  logic [3:0]    video_out_q, video_out_d;
  logic          de_q, de_d;
  logic          hs_out_q, vs_out_q;

  logic          h_edge, v_edge, win;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_video_q   <= 4'h0;
      s1_hs_q      <= SyncOff;
      s1_vs_q      <= SyncOff;
      s1_hs_prev_q <= SyncOff;
      s1_vs_prev_q <= SyncOff;
    end else begin
      s1_video_q   <= video;
      s1_hs_q      <= hsync;
      s1_vs_q      <= vsync;
      s1_hs_prev_q <= s1_hs_q;
      s1_vs_prev_q <= s1_vs_q;
    end
  end

  always_comb begin
    h_edge = (s1_hs_q == SYNC_POL) && (s1_hs_prev_q != SYNC_POL);
    v_edge = (s1_vs_q == SYNC_POL) && (s1_vs_prev_q != SYNC_POL);

    // Saturate rather than wrap so a missing hsync cannot reopen the window.
    if (h_edge) begin
      h_cnt_d = '0;
    end else if (h_cnt_q == HMax) begin
      h_cnt_d = HMax;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end

    // vsync edge takes priority over a coincident hsync edge.
    v_cnt_d = v_cnt_q;
    if (v_edge) begin
      v_cnt_d = '0;
    end else if (h_edge && (v_cnt_q != VMax)) begin
      v_cnt_d = v_cnt_q + 1'b1;
    end

    // Frame length is taken from the count before the clear.
    frame_lines_d = frame_lines_q;
    locked_d      = locked_q;
    if (v_edge) begin
      frame_lines_d = v_cnt_q;
      locked_d      = (v_cnt_q == frame_lines_q) && (v_cnt_q != '0);
    end

    // Full 32-bit comparison so window bounds beyond the counter range are not truncated.
    win = (32'(h_cnt_d) >= H_START) && (32'(h_cnt_d) < HEnd) &&
          (32'(v_cnt_d) >= V_START) && (32'(v_cnt_d) < VEnd);

    de_d        = win && (locked_q || !REQ_LOCK);
    video_out_d = de_d ? s1_video_q : 4'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_lines_q <= '0;
      locked_q      <= 1'b0;
      video_out_q   <= 4'h0;
      de_q          <= 1'b0;
      hs_out_q      <= SyncOff;
      vs_out_q      <= SyncOff;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_lines_q <= frame_lines_d;
      locked_q      <= locked_d;
      video_out_q   <= video_out_d;
      de_q          <= de_d;
      hs_out_q      <= s1_hs_q;
      vs_out_q      <= s1_vs_q;
    end
  end

  assign video_out = video_out_q;
  assign de_out    = de_q;
  assign hsync_out = hs_out_q;
  assign vsync_out = vs_out_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_cga_hdmi_de_gen.sv
// Directed bench for cga_hdmi_de_gen. Three instances share one stimulus stream:
//   a: REQ_LOCK=0, active-high syncs (DE timing independent of lock)
//   b: REQ_LOCK=1, active-high syncs (lock behaviour)
//   c: REQ_LOCK=0, active-low syncs driven with the inverted sync stream
// Lines are short (2 dots) except where a dot position is probed, which keeps whole frames cheap.
module tb_cga_hdmi_de_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] video = 4'h0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic       c_hsync, c_vsync;

  logic [3:0] a_vid, b_vid, c_vid;
  logic       a_de, a_hs, a_vs, a_lock;
  logic       b_de, b_hs, b_vs, b_lock;
  logic       c_de, c_hs, c_vs, c_lock;

  int checks = 0;
  int errors = 0;

  assign c_hsync = ~hsync;
  assign c_vsync = ~vsync;

  always #5 clk = ~clk;

  cga_hdmi_de_gen #(.REQ_LOCK(1'b0)) u_a (
    .clk(clk), .reset_n(reset_n), .video(video), .hsync(hsync), .vsync(vsync),
    .video_out(a_vid), .de_out(a_de), .hsync_out(a_hs), .vsync_out(a_vs), .locked(a_lock)
  );

  cga_hdmi_de_gen u_b (
    .clk(clk), .reset_n(reset_n), .video(video), .hsync(hsync), .vsync(vsync),
    .video_out(b_vid), .de_out(b_de), .hsync_out(b_hs), .vsync_out(b_vs), .locked(b_lock)
  );

  cga_hdmi_de_gen #(.SYNC_POL(1'b0), .REQ_LOCK(1'b0)) u_c (
    .clk(clk), .reset_n(reset_n), .video(video), .hsync(c_hsync), .vsync(c_vsync),
    .video_out(c_vid), .de_out(c_de), .hsync_out(c_hs), .vsync_out(c_vs), .locked(c_lock)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one dot, then sample 1 time unit after the capturing edge.
  task automatic step(input logic [3:0] v, input logic hs, input logic vs);
    video = v;
    hsync = hs;
    vsync = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_vid"}, a_vid, 4'h0);
    check({tag, "_a_de"}, a_de, 1'b0);
    check({tag, "_a_lock"}, a_lock, 1'b0);
    check({tag, "_a_hs"}, a_hs, 1'b0);
    check({tag, "_a_vs"}, a_vs, 1'b0);
    check({tag, "_b_vid"}, b_vid, 4'h0);
    check({tag, "_b_de"}, b_de, 1'b0);
    check({tag, "_b_lock"}, b_lock, 1'b0);
    check({tag, "_c_vid"}, c_vid, 4'h0);
    check({tag, "_c_de"}, c_de, 1'b0);
    check({tag, "_c_hs"}, c_hs, 1'b1);
    check({tag, "_c_vs"}, c_vs, 1'b1);
  endtask

  // One line: hsync on dot 0 only. Dot 'probe' carries 4'hA, all others 4'h5. Its outputs are
  // due exactly two clocks after it is applied, and must not show up one clock after.
  task automatic run_line(input int len, input int probe, input logic exp_ac, input logic exp_b,
                          input string tag);
    for (int d = 0; d < len; d++) begin
      step((d == probe) ? 4'hA : 4'h5, (d == 0), 1'b0);
      if (probe >= 0 && d == probe) check({tag, "_early"}, {3'b0, a_vid == 4'hA}, 4'h0);
      if (probe >= 0 && d == probe + 1) begin
        check({tag, "_a_de"}, a_de, exp_ac);
        check({tag, "_a_vid"}, a_vid, exp_ac ? 4'hA : 4'h0);
        check({tag, "_b_de"}, b_de, exp_b);
        check({tag, "_b_vid"}, b_vid, exp_b ? 4'hA : 4'h0);
        check({tag, "_c_de"}, c_de, exp_ac);
        check({tag, "_c_vid"}, c_vid, exp_ac ? 4'hA : 4'h0);
      end
    end
  endtask

  // Line 0 of a frame: vsync and hsync leading edges on the same dot, so it is line 0.
  task automatic frame_start(input logic exp_prev, input logic exp_new);
    step(4'h5, 1'b1, 1'b1);
    check("lock_pre_a", a_lock, exp_prev);
    check("lock_pre_b", b_lock, exp_prev);
    check("hs_pre_a", a_hs, 1'b0);
    step(4'h5, 1'b0, 1'b1);
    check("lock_post_a", a_lock, exp_new);
    check("lock_post_b", b_lock, exp_new);
    check("hs_out_a", a_hs, 1'b1);
    check("vs_out_a", a_vs, 1'b1);
    check("hs_out_c", c_hs, 1'b0);
    check("vs_out_c", c_vs, 1'b0);
  endtask

  // Lines 1..nlines-1 of a frame. Line 36 always probes the first active dot.
  task automatic frame(input int nlines, input bit full, input logic exp_b);
    for (int i = 1; i < nlines; i++) begin
      if (i == 36) run_line(200, 120, 1'b1, exp_b, "v36_h120");
      else if (full && i == 35) run_line(200, 120, 1'b0, 1'b0, "v35_h120");
      else if (full && i == 37) run_line(200, 119, 1'b0, 1'b0, "h119");
      else if (full && i == 38) run_line(770, 759, 1'b1, exp_b, "h759");
      else if (full && i == 39) run_line(770, 760, 1'b0, 1'b0, "h760");
      // 1150-dot line: a wrapping counter would reach 120 again at dot 1144.
      else if (full && i == 40) run_line(1150, 1144, 1'b0, 1'b0, "hsat");
      else if (full && i == 41) run_line(200, 120, 1'b1, exp_b, "after_sat");
      else if (full && i == 235) run_line(200, 120, 1'b1, exp_b, "v235");
      else if (full && i == 236) run_line(200, 120, 1'b0, 1'b0, "v236");
      else run_line(2, -1, 1'b0, 1'b0, "idle");
    end
  endtask

  initial begin
    // Reset held with toggling syncs and white video.
    for (int k = 0; k < 6; k++) step(4'hF, k[0], ~k[0]);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step(4'h5, 1'b0, 1'b0);

    frame_start(1'b0, 1'b0);
    frame(262, 1'b1, 1'b0);   // window edges, saturation
    frame_start(1'b0, 1'b0);
    frame(262, 1'b0, 1'b0);
    frame_start(1'b0, 1'b1);  // second equal frame completes: lock
    frame(262, 1'b0, 1'b1);
    frame_start(1'b1, 1'b1);
    frame(263, 1'b0, 1'b1);
    frame_start(1'b1, 1'b0);  // 263-line frame breaks lock
    frame(262, 1'b0, 1'b0);
    frame_start(1'b0, 1'b0);
    frame(262, 1'b0, 1'b0);
    frame_start(1'b0, 1'b1);
    frame(40, 1'b0, 1'b1);

    // Mid-frame reset while locked and with syncs active.
    step(4'hF, 1'b1, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_b_lock", b_lock, 1'b0);
    step(4'hF, 1'b1, 1'b1);
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    step(4'h5, 1'b0, 1'b0);

    frame_start(1'b0, 1'b0);
    frame(262, 1'b0, 1'b0);
    frame_start(1'b0, 1'b0);
    frame(262, 1'b0, 1'b0);
    frame_start(1'b0, 1'b1);  // lock regained after two full frames
    frame(40, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
